// File: rtl/axi_wr_data_fifo.sv
// axi_wr_data_fifo: DEPTH-entry buffer for the AXI write data (W) channel.
//
// Sits between a W-channel master (s_*) and slave (m_*). Beats are stored in
// order and presented at the head with one cycle of fall-through latency. The
// block also reports how many beats are held (level) and how many complete
// bursts are held (bursts, i.e. beats with wlast=1).
//
// Ports:
//   aclk, aresetn                     clock, synchronous active-low reset
//   s_wid/s_wdata/s_wstrb/s_wlast     upstream beat
//   s_wvalid / s_wready               upstream handshake (s_wready = !full)
//   m_wid/m_wdata/m_wstrb/m_wlast     downstream beat (FIFO head)
//   m_wvalid / m_wready               downstream handshake
//   level, bursts                     beats held, complete bursts held
//   full, empty                       level==DEPTH, level==0
//
// Optional build macro AXI_WR_DATA_FIFO_SF_EN: store-and-forward. A burst is
// released only once its wlast beat is buffered, or when the FIFO is full
// (escape for bursts longer than DEPTH). Without it the FIFO is cut-through.
module axi_wr_data_fifo #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [ID_WIDTH-1:0]           s_wid,
  input  logic [DATA_WIDTH-1:0]         s_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_wstrb,
  input  logic                          s_wlast,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [ID_WIDTH-1:0]           m_wid,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_wstrb,
  output logic                          m_wlast,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [$clog2(DEPTH):0]        level,
  output logic [$clog2(DEPTH):0]        bursts,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned StrbW  = DATA_WIDTH / 8;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = ID_WIDTH + DATA_WIDTH + StrbW + 1;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] head;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] level_q, level_d;
  logic [CntW-1:0] bursts_q, bursts_d;

  logic push, pop;

  // Status comes straight from registered counters: no m_wready -> s_wready path.
  assign full     = (level_q == CntW'(DEPTH));
  assign empty    = (level_q == '0);
  assign s_wready = ~full;
  assign level    = level_q;
  assign bursts   = bursts_q;

  assign head = mem_q[rd_ptr_q];
  assign {m_wid, m_wdata, m_wstrb, m_wlast} = head;

`ifdef AXI_WR_DATA_FIFO_SF_EN
  // hold_q keeps m_wvalid up once offered and not yet taken, so the full-escape
  // release cannot be withdrawn when level drops below DEPTH.
  logic hold_q, hold_d;

  assign m_wvalid = ~empty & ((bursts_q != '0) | full | hold_q);
  assign hold_d   = m_wvalid & ~m_wready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign m_wvalid = ~empty;
`endif

  assign push = s_wvalid & s_wready;
  assign pop  = m_wvalid & m_wready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    bursts_d = bursts_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + CntW'(1);
      2'b01:   level_d = level_q - CntW'(1);
      default: level_d = level_q;
    endcase

    unique case ({push & s_wlast, pop & m_wlast})
      2'b10:   bursts_d = bursts_q + CntW'(1);
      2'b01:   bursts_d = bursts_q - CntW'(1);
      default: bursts_d = bursts_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      bursts_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      bursts_q <= bursts_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_wid, s_wdata, s_wstrb, s_wlast};
    end
  end

endmodule

// File: tb/tb_axi_wr_data_fifo.sv
module tb_axi_wr_data_fifo;

  localparam int unsigned IdW   = 4;
  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 16;

  typedef struct packed {
    logic [IdW-1:0]     id;
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } beat_t;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic [IdW-1:0]       s_wid;
  logic [DataW-1:0]     s_wdata;
  logic [DataW/8-1:0]   s_wstrb;
  logic                 s_wlast;
  logic                 s_wvalid;
  logic                 s_wready;
  logic [IdW-1:0]       m_wid;
  logic [DataW-1:0]     m_wdata;
  logic [DataW/8-1:0]   m_wstrb;
  logic                 m_wlast;
  logic                 m_wvalid;
  logic                 m_wready;
  logic [$clog2(Depth):0] level;
  logic [$clog2(Depth):0] bursts;
  logic                 full;
  logic                 empty;

  axi_wr_data_fifo #(
    .ID_WIDTH  (IdW),
    .DATA_WIDTH(DataW),
    .DEPTH     (Depth)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_wid   (s_wid),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_wlast (s_wlast),
    .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .m_wid   (m_wid),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_wlast (m_wlast),
    .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .level   (level),
    .bursts  (bursts),
    .full    (full),
    .empty   (empty)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int popped = 0;

  // Reference model: ordered list of held beats plus the "offered, not yet
  // taken" flag that keeps a store-and-forward release stable.
  beat_t model_q[$];
  bit    hold_m = 1'b0;
  logic  acc;

  function automatic int n_bursts();
    int n = 0;
    foreach (model_q[i]) if (model_q[i].last) n++;
    return n;
  endfunction

  function automatic bit exp_mv();
`ifdef AXI_WR_DATA_FIFO_SF_EN
    return (model_q.size() != 0) &&
           (n_bursts() != 0 || model_q.size() == Depth || hold_m);
`else
    return model_q.size() != 0;
`endif
  endfunction

  function automatic beat_t mk(input int id, input int data, input int strb, input bit last);
    beat_t b;
    b.id   = IdW'(id);
    b.data = DataW'(data);
    b.strb = (DataW/8)'(strb);
    b.last = last;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    beat_t h;
    chk("level", 64'(level), 64'(model_q.size()));
    chk("bursts", 64'(bursts), 64'(n_bursts()));
    chk("full", 64'(full), 64'(model_q.size() == Depth));
    chk("empty", 64'(empty), 64'(model_q.size() == 0));
    chk("s_wready", 64'(s_wready), 64'(model_q.size() != Depth));
    chk("m_wvalid", 64'(m_wvalid), 64'(exp_mv()));
    if (exp_mv()) begin
      h = model_q[0];
      chk("head", 64'({m_wid, m_wdata, m_wstrb, m_wlast}), 64'(h));
    end
  endtask

  // One clock: drive, let the edge happen, update the model, check #1 later.
  task automatic step(input logic v, input beat_t b, input logic r, output logic accepted);
    bit push, pop, mv;
    s_wvalid = v;
    {s_wid, s_wdata, s_wstrb, s_wlast} = b;
    m_wready = r;
    mv   = exp_mv();
    push = v && (model_q.size() < Depth);
    pop  = mv && r;
    @(posedge aclk);
    if (pop) begin
      void'(model_q.pop_front());
      popped++;
    end
    if (push) model_q.push_back(b);
    hold_m   = mv && !pop;
    accepted = push;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_wvalid = 1'b0;
    m_wready = 1'b0;
    @(posedge aclk);
    model_q.delete();
    hold_m = 1'b0;
    #1;
    aresetn = 1'b1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && model_q.size() != 0; i++) begin
      step(1'b0, mk(0, 0, 0, 0), 1'b1, acc);
    end
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    int idx;
    aresetn  = 1'b0;
    s_wvalid = 1'b0;
    m_wready = 1'b0;
    {s_wid, s_wdata, s_wstrb, s_wlast} = '0;
    do_reset();
    chk("rst_sready", 64'(s_wready), 64'd1);
    chk("rst_mvalid", 64'(m_wvalid), 64'd0);

    // Single beat, fall-through and pop.
    step(1'b1, mk(3, 32'hA5A5A5A5, 4'hF, 1'b1), 1'b1, acc);
    chk("t1_mvalid", 64'(m_wvalid), 64'd1);
    chk("t1_wdata", 64'(m_wdata), 64'hA5A5A5A5);
    chk("t1_level", 64'(level), 64'd1);
    step(1'b0, mk(0, 0, 0, 0), 1'b1, acc);
    chk("t1_level_after", 64'(level), 64'd0);
    chk("t1_bursts_after", 64'(bursts), 64'd0);

    // Fill to DEPTH with no downstream ready, then free one slot.
    for (int i = 0; i < Depth; i++) begin
      step(1'b1, mk(i, 32'h2000 + i, 4'hF, (i % 4) == 3), 1'b0, acc);
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_sready", 64'(s_wready), 64'd0);
    chk("fill_level", 64'(level), 64'd16);
    step(1'b1, mk(7, 32'h2010, 4'h3, 1'b1), 1'b0, acc);
    chk("fill_reject", 64'(acc), 64'd0);
    step(1'b0, mk(0, 0, 0, 0), 1'b1, acc);
    chk("pop_sready", 64'(s_wready), 64'd1);
    step(1'b1, mk(7, 32'h2010, 4'h3, 1'b1), 1'b0, acc);
    chk("beat17_level", 64'(level), 64'd16);
    drain();

    // Simultaneous push and pop at level 5, wlast on both.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(i, 32'h3000 + i, 4'hF, 1'b1), 1'b0, acc);
    end
    step(1'b1, mk(9, 32'h3005, 4'hF, 1'b1), 1'b1, acc);
    chk("sim_level", 64'(level), 64'd5);
    chk("sim_bursts", 64'(bursts), 64'd5);
    drain();

    // Random valid/ready stream of 40 beats in 4-beat bursts.
    popped = 0;
    idx    = 0;
    for (int cyc = 0; cyc < 3000 && (idx < 40 || model_q.size() != 0); cyc++) begin
      logic v, r;
      v = (idx < 40) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      step(v, mk(idx / 4, 32'h1000 + idx, $urandom_range(0, 15), (idx % 4) == 3), r, acc);
      if (acc) idx++;
    end
    chk("stream_pushed", 64'(idx), 64'd40);
    chk("stream_popped", 64'(popped), 64'd40);
    chk("stream_empty", 64'(empty), 64'd1);

`ifdef AXI_WR_DATA_FIFO_SF_EN
    // Store-and-forward: hold until wlast, escape when full.
    for (int i = 0; i < 3; i++) step(1'b1, mk(1, 32'h4000 + i, 4'hF, 1'b0), 1'b0, acc);
    chk("sf_wait", 64'(m_wvalid), 64'd0);
    step(1'b1, mk(1, 32'h4003, 4'hF, 1'b1), 1'b0, acc);
    chk("sf_release", 64'(m_wvalid), 64'd1);
    drain();
    idx = 0;
    for (int i = 0; i < Depth; i++) begin
      step(1'b1, mk(2, 32'h5000 + idx, 4'hF, 1'b0), 1'b0, acc);
      if (acc) idx++;
      if (i < Depth - 1) chk("sf_long_wait", 64'(m_wvalid), 64'd0);
    end
    chk("sf_full", 64'(full), 64'd1);
    chk("sf_escape", 64'(m_wvalid), 64'd1);
    for (int cyc = 0; cyc < 200 && idx < 20; cyc++) begin
      step(1'b1, mk(2, 32'h5000 + idx, 4'hF, 1'b0), 1'b1, acc);
      if (acc) idx++;
    end
    chk("sf_long_pushed", 64'(idx), 64'd20);
    for (int cyc = 0; cyc < 200; cyc++) begin
      step(1'b1, mk(2, 32'h5014, 4'hF, 1'b1), 1'b1, acc);
      if (acc) break;
    end
    drain();
`endif

    // Reset in the middle of operation.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, mk(i, 32'h6000 + i, 4'hF, (i % 2) == 1), 1'b0, acc);
    end
    chk("pre_rst_level", 64'(level), 64'd7);
    do_reset();
    chk("rst2_level", 64'(level), 64'd0);
    chk("rst2_bursts", 64'(bursts), 64'd0);
    chk("rst2_mvalid", 64'(m_wvalid), 64'd0);
    chk("rst2_sready", 64'(s_wready), 64'd1);

    // Traffic still works after the mid-run reset.
    step(1'b1, mk(5, 32'h7777, 4'h5, 1'b1), 1'b0, acc);
    step(1'b0, mk(0, 0, 0, 0), 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
